// File: rtl/cnt_seq.sv
// -----------------------------------------------------------------------------
// cnt_seq -- run controller for a counter with a divisible-by-3 flag.
//
// The controller counts from 0 up to a limit that is latched when a run starts.
// Each value is evaluated once. The block counts how many evaluated values are
// multiples of 3 and gives a one-cycle done pulse when the run completes.
// Software can pause, resume or abort a run.
//
// Divisibility by 3 comes from a mod-3 residue register that advances with
// the count, so the design needs no divider.
//
// Optional feature (macro CNT_SEQ_AUTORESTART_EN):
//   When the macro is defined, DONE goes back to RUN with the counters cleared
//   and the latched limit reused. Runs repeat until abort or reset.
//
// Parameters:
//   W        counter, limit and hit-count width (W >= 2)
// Ports:
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset
//   start    begin a run (sampled only in IDLE)
//   limit    terminal count, latched when start is accepted
//   pause    level: freeze the run while high
//   abort    level: cancel an active run
//   out      current count value
//   chk_3    1 when out is a multiple of 3
//   hit_cnt  number of evaluated values that were multiples of 3
//   busy     run active (RUN or HOLD)
//   done     one-cycle completion pulse
// -----------------------------------------------------------------------------
module cnt_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] limit,
  input  logic         pause,
  input  logic         abort,
  output logic [W-1:0] out,
  output logic         chk_3,
  output logic [W-1:0] hit_cnt,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state, state_nxt;
  logic [W-1:0] lim_q, lim_nxt;
  logic [W-1:0] out_nxt, hit_nxt;
  logic [1:0]   res_q, res_nxt;

  // NOTE: give every always_comb output a default before the case statement.
  // A path that leaves an output unassigned infers a latch.
  always_comb begin
    state_nxt = state;
    lim_nxt   = lim_q;
    out_nxt   = out;
    hit_nxt   = hit_cnt;
    res_nxt   = res_q;

    case (state)
      IDLE: begin
        if (start) begin
          lim_nxt   = limit;
          out_nxt   = '0;
          hit_nxt   = '0;
          res_nxt   = 2'd0;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (pause) begin
          state_nxt = HOLD;
        end else begin
          if (chk_3) hit_nxt = hit_cnt + W'(1);
          // Stop at the limit without incrementing. An all-ones limit
          // therefore never wraps the counter.
          if (out == lim_q) begin
            state_nxt = DONE;
          end else begin
            out_nxt = out + W'(1);
            res_nxt = (res_q == 2'd2) ? 2'd0 : res_q + 2'd1;
          end
        end
      end

      HOLD: begin
        if (abort)       state_nxt = IDLE;
        else if (!pause) state_nxt = RUN;
      end

      DONE: begin
`ifdef CNT_SEQ_AUTORESTART_EN
        out_nxt   = '0;
        hit_nxt   = '0;
        res_nxt   = 2'd0;
        state_nxt = RUN;
`else
        state_nxt = IDLE;
`endif
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      lim_q   <= '0;
      out     <= '0;
      hit_cnt <= '0;
      res_q   <= 2'd0;
    end else begin
      state   <= state_nxt;
      lim_q   <= lim_nxt;
      out     <= out_nxt;
      hit_cnt <= hit_nxt;
      res_q   <= res_nxt;
    end
  end

  assign chk_3 = (res_q == 2'd0);
  assign busy  = (state == RUN) || (state == HOLD);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_cnt_seq.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq -- directed testbench for cnt_seq (W = 16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_cnt_seq;

  localparam int W = 16;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [W-1:0] limit;
  logic         pause;
  logic         abort;
  logic [W-1:0] out;
  logic         chk_3;
  logic [W-1:0] hit_cnt;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  cnt_seq #(.W(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .limit   (limit),
    .pause   (pause),
    .abort   (abort),
    .out     (out),
    .chk_3   (chk_3),
    .hit_cnt (hit_cnt),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check every output at once. The expected chk_3 is derived from the
  // expected count.
  task automatic check_all(input string tag, input int e_out, input int e_hit,
                           input bit e_busy, input bit e_done);
    check({tag, ".out"},   32'(out),     32'(e_out));
    check({tag, ".chk_3"}, 32'(chk_3),   32'((e_out % 3) == 0));
    check({tag, ".hit"},   32'(hit_cnt), 32'(e_hit));
    check({tag, ".busy"},  32'(busy),    32'(e_busy));
    check({tag, ".done"},  32'(done),    32'(e_done));
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    limit = '0;
    pause = 1'b0;
    abort = 1'b0;

    // ---------------- reset values ----------------
    #2;
    check_all("reset", 0, 0, 1'b0, 1'b0);
    #10 rstn = 1'b1;            // released between edges
    step();
    check_all("idle", 0, 0, 1'b0, 1'b0);

`ifndef CNT_SEQ_AUTORESTART_EN
    // ---------------- limit = 6 ----------------
    start = 1'b1; limit = 16'd6;
    step();
    start = 1'b0; limit = 16'd99; // changes after acceptance are ignored
    // Values 0..6 are visible in RUN. Hits occur at 0, 3 and 6.
    for (int v = 0; v <= 6; v++) begin
      check_all("l6.run", v, (v + 2) / 3, 1'b1, 1'b0);
      step();
    end
    check_all("l6.done", 6, 3, 1'b0, 1'b1);
    step();
    check_all("l6.idle", 6, 3, 1'b0, 1'b0);

    // ---------------- limit = 0 ----------------
    start = 1'b1; limit = 16'd0;
    step();
    start = 1'b0;
    check_all("l0.run", 0, 0, 1'b1, 1'b0);
    step();
    check_all("l0.done", 0, 1, 1'b0, 1'b1);
    start = 1'b1; limit = 16'd3; // start in the DONE cycle is ignored
    step();
    start = 1'b0;
    check_all("l0.idle", 0, 1, 1'b0, 1'b0);
    step();
    check_all("l0.idle2", 0, 1, 1'b0, 1'b0);

    // ---------------- limit = 10 with a 3-cycle pause at 4 ----------------
    start = 1'b1; limit = 16'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_all("l10.at4", 4, 2, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("l10.hold", 4, 2, 1'b1, 1'b0);
    end
    pause = 1'b0;
    step();                      // HOLD -> RUN, no evaluation yet
    for (int v = 4; v <= 10; v++) begin
      check_all("l10.run", v, (v + 2) / 3, 1'b1, 1'b0);
      step();
    end
    check_all("l10.done", 10, 4, 1'b0, 1'b1);
    step();
    check_all("l10.idle", 10, 4, 1'b0, 1'b0);

    // ---------------- limit = 300, abort at 150, start pulsed while busy ----
    start = 1'b1; limit = 16'd300;
    step();
    start = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (i == 20) begin start = 1'b1; limit = 16'd5; end
      if (i == 21) start = 1'b0;
      check("l300.busy", 32'(busy), 32'd1);
      step();
    end
    check_all("l300.at150", 150, 50, 1'b1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_all("l300.abort", 150, 50, 1'b0, 1'b0);
    step();
    check_all("l300.idle", 150, 50, 1'b0, 1'b0);

    // ---------------- limit = 20, asynchronous reset mid-RUN ----------------
    start = 1'b1; limit = 16'd20;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check_all("l20.at7", 7, 3, 1'b1, 1'b0);
    #3 rstn = 1'b0;             // asserted between edges
    #1;
    check_all("l20.rst", 0, 0, 1'b0, 1'b0);
    step();
    check_all("l20.rst_hold", 0, 0, 1'b0, 1'b0);
    #2 rstn = 1'b1;
    step();
    check_all("l20.post", 0, 0, 1'b0, 1'b0);
`else
    // ---------------- autorestart, limit = 5 ----------------
    start = 1'b1; limit = 16'd5;
    step();
    start = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v <= 5; v++) begin
        check_all("ar.run", v, (v + 2) / 3, 1'b1, 1'b0);
        step();
      end
      check_all("ar.done", 5, 2, 1'b0, 1'b1);
      step();
    end
    check_all("ar.restart", 0, 0, 1'b1, 1'b0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_all("ar.abort", 1, 1, 1'b0, 1'b0);
    step();
    check_all("ar.idle", 1, 1, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
